nmr_scan_scheduler: RTL
=======================

# nmr_scan_scheduler

Multi-scan controller for the NMR pulse-sequence bit streamer. It repeats a full sequence playback NUM_SCANS times, with a programmable repetition delay (TR) between scans and an optional 4-step phase-cycle index for the downstream TX/ACQ phase selection. The block sits between the host control registers and the streamer's START/DONE/RST pins. It clears the streamer's sticky DONE flag before every scan.

## Interface
Parameters:
- SCAN_WIDTH, 16, width of the scan count and scan index
- TR_WIDTH, 32, width of the repetition-delay counter, in CLK cycles

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous, active-low reset
- RUN  in  1  level; start request, held high for the whole run
- ABORT  in  1  level; terminate the run early
- NUM_SCANS  in  SCAN_WIDTH  number of scans, latched at start
- TR_CYCLES  in  TR_WIDTH  delay from streamer DONE to next scan's streamer reset, latched at start
- PHASE_CYC_EN  in  1  enables phase-cycle stepping, latched at start
- STR_START  out  1  streamer START level
- STR_DONE  in  1  streamer DONE, sticky until streamer reset
- STR_RST  out  1  active-high, one-cycle streamer reset pulse
- SCAN_IDX  out  SCAN_WIDTH  index of the current scan, 0-based
- SCAN_PHASE  out  2  phase-cycle step of the current scan
- BUSY  out  1  run in progress
- DONE  out  1  run finished; held until RUN falls
- ABORTED  out  1  last run ended by ABORT; valid while DONE=1

## Operation
- One clock, CLK. Reset is synchronous and active-low on RST_N.
- All outputs are registered. Reset values are 0 for all outputs, and state is IDLE. Reset mid-run takes effect at the next edge and forces all outputs to 0, including an immediate drop of STR_START.
- States: IDLE, CLR, ARM, WAIT, TR, NEXT, FIN.
- IDLE
  - If RUN=1: latch NUM_SCANS, TR_CYCLES and PHASE_CYC_EN.
  - Set SCAN_IDX=0, SCAN_PHASE=0, BUSY=1, ABORTED=0, STR_RST=1, then go to CLR.
  - If the latched NUM_SCANS=0: go to FIN instead, with BUSY=0, DONE=1 and no streamer activity.
- CLR: STR_RST=0, go to ARM.
- ARM: STR_START=1, go to WAIT.
- WAIT
  - Hold STR_START=1 until STR_DONE=1.
  - On STR_DONE=1: STR_START=0 and load tr_cnt=TR_CYCLES. Go to TR if TR_CYCLES≠0, otherwise go to NEXT.
- TR: if tr_cnt==1 go to NEXT, else decrement tr_cnt. TR therefore lasts exactly TR_CYCLES cycles.
- NEXT
  - If SCAN_IDX+1 == NUM_SCANS: go to FIN with BUSY=0 and DONE=1. SCAN_IDX keeps its final value, NUM_SCANS-1.
  - Otherwise: SCAN_IDX+1; SCAN_PHASE+1 (mod 4) if PHASE_CYC_EN, else SCAN_PHASE stays 0. Set STR_RST=1 and go to CLR.
- FIN: hold DONE. When RUN=0: DONE=0, ABORTED=0, go to IDLE. SCAN_IDX is held until the next start.
- ABORT=1, sampled in CLR, ARM, WAIT, TR or NEXT, has priority over all other transitions:
  - STR_START=0, STR_RST=1 for one cycle, BUSY=0, DONE=1, ABORTED=1, go to FIN.
  - The STR_RST pulse is deasserted on the FIN entry +1 edge.
- ABORT is ignored in IDLE and FIN.
- RUN falling mid-run is ignored. The run completes and DONE clears once RUN is low in FIN.
- Comparison SCAN_IDX+1 == NUM_SCANS uses SCAN_WIDTH+1 bits, so NUM_SCANS = all-ones does not wrap. SCAN_PHASE wraps 3→0.
- Config inputs are not re-sampled during a run.

## Timing
- Start latency: RUN sampled at edge 0 gives STR_RST=1 after edge 0, STR_RST=0 after edge 1, and STR_START=1 after edge 2.
- Inter-scan gap: STR_START is low for exactly TR_CYCLES+3 cycles between the WAIT edge that samples STR_DONE=1 and the next STR_START rise. The minimum gap is 3 cycles at TR_CYCLES=0.
- Within that gap, STR_RST is a single-cycle pulse, asserted 2 cycles before STR_START rises.
- SCAN_IDX and SCAN_PHASE update on the NEXT edge, before STR_RST. They are stable for the whole scan.
- DONE rises one cycle after the last TR expires, i.e. on the NEXT edge. It falls on the first FIN edge that samples RUN=0.
- STR_DONE is not examined outside WAIT. A stale DONE from the previous scan is cleared by the STR_RST pulse and cannot shortcut WAIT.

## Test plan
- NUM_SCANS=3, TR_CYCLES=10, PHASE_CYC_EN=1, streamer model asserting DONE 50 cycles after START.
  - Expect 3 STR_START pulses, each 50 cycles, separated by gaps of 13 cycles.
  - SCAN_IDX goes 0,1,2 and SCAN_PHASE goes 0,1,2.
  - DONE rises 11 cycles after the third STR_DONE. SCAN_IDX=2 in FIN.
- NUM_SCANS=6, PHASE_CYC_EN=1, TR_CYCLES=0 → SCAN_PHASE sequence 0,1,2,3,0,1; gaps of 3 cycles; 6 STR_RST pulses total. Repeat with PHASE_CYC_EN=0 → SCAN_PHASE stays 0.
- NUM_SCANS=0, RUN=1 → DONE=1 after one edge, BUSY stays 0, no STR_START and no STR_RST activity.
- ABORT asserted during TR of scan 1 (NUM_SCANS=5) → next edge gives STR_START=0, one STR_RST pulse, DONE=1, ABORTED=1, SCAN_IDX=1. Dropping RUN then clears DONE and ABORTED and returns to IDLE.
- STR_DONE held at 1 permanently until STR_RST (sticky model), NUM_SCANS=2 → each scan's WAIT lasts at least one full streamer run; there is no zero-length scan.
- RST_N=0 for one cycle during WAIT of scan 2 → all outputs 0 after that edge. A new RUN restarts from SCAN_IDX=0 with the normal 2-cycle start latency.

Source files
------------

// File: rtl/nmr_scan_scheduler.sv
// nmr_scan_scheduler: repeats a full streamer playback NUM_SCANS times with a TR gap between scans
//
// Ports:
//   CLK           system clock
//   RST_N         synchronous, active-low reset
//   RUN           level start request, held high for the whole run
//   ABORT         level request to end the run early
//   NUM_SCANS     scan count, latched at start
//   TR_CYCLES     streamer DONE to next streamer reset delay in CLK cycles, latched at start
//   PHASE_CYC_EN  enables the 4-step phase cycle, latched at start
//   STR_START     streamer START level
//   STR_DONE      streamer DONE, sticky until the streamer is reset
//   STR_RST       one-cycle, active-high streamer reset pulse
//   SCAN_IDX      0-based index of the current scan
//   SCAN_PHASE    phase-cycle step of the current scan
//   BUSY          run in progress
//   DONE          run finished, held until RUN falls
//   ABORTED       last run ended by ABORT, valid while DONE is high
module nmr_scan_scheduler #(
    parameter int SCAN_WIDTH = 16,
    parameter int TR_WIDTH   = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  RUN,
    input  logic                  ABORT,
    input  logic [SCAN_WIDTH-1:0] NUM_SCANS,
    input  logic [TR_WIDTH-1:0]   TR_CYCLES,
    input  logic                  PHASE_CYC_EN,
    output logic                  STR_START,
    input  logic                  STR_DONE,
    output logic                  STR_RST,
    output logic [SCAN_WIDTH-1:0] SCAN_IDX,
    output logic [1:0]            SCAN_PHASE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ABORTED
);

    typedef enum logic [2:0] {IDLE, CLR, ARM, WAIT, TR, NEXT, FIN} state_t;

    state_t                state, state_d;
    logic [SCAN_WIDTH-1:0] num_q, num_d;
    logic [TR_WIDTH-1:0]   tr_q, tr_d;
    logic                  pce_q, pce_d;
    logic [TR_WIDTH-1:0]   tr_cnt, cnt_d;
    logic                  start_d, rst_d, busy_d, done_d, abt_d;
    logic [SCAN_WIDTH-1:0] idx_d;
    logic [1:0]            ph_d;
    logic                  abort_ok, last_scan;

    // ABORT only acts while the streamer is being driven
    assign abort_ok  = ABORT && (state inside {CLR, ARM, WAIT, TR, NEXT});
    // one extra bit so an all-ones scan count cannot wrap to a false match
    assign last_scan = ({1'b0, SCAN_IDX} + (SCAN_WIDTH+1)'(1)) == {1'b0, num_q};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            num_q      <= '0;
            tr_q       <= '0;
            pce_q      <= 1'b0;
            tr_cnt     <= '0;
            STR_START  <= 1'b0;
            STR_RST    <= 1'b0;
            SCAN_IDX   <= '0;
            SCAN_PHASE <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ABORTED    <= 1'b0;
        end else begin
            state      <= state_d;
            num_q      <= num_d;
            tr_q       <= tr_d;
            pce_q      <= pce_d;
            tr_cnt     <= cnt_d;
            STR_START  <= start_d;
            STR_RST    <= rst_d;
            SCAN_IDX   <= idx_d;
            SCAN_PHASE <= ph_d;
            BUSY       <= busy_d;
            DONE       <= done_d;
            ABORTED    <= abt_d;
        end
    end

    always_comb begin
        state_d = state;
        num_d   = num_q;
        tr_d    = tr_q;
        pce_d   = pce_q;
        cnt_d   = tr_cnt;
        start_d = STR_START;
        rst_d   = 1'b0;
        idx_d   = SCAN_IDX;
        ph_d    = SCAN_PHASE;
        busy_d  = BUSY;
        done_d  = DONE;
        abt_d   = ABORTED;
        if (abort_ok) begin
            start_d = 1'b0;
            rst_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            abt_d   = 1'b1;
            state_d = FIN;
        end else begin
            case (state)
                IDLE: if (RUN) begin
                    num_d = NUM_SCANS;
                    tr_d  = TR_CYCLES;
                    pce_d = PHASE_CYC_EN;
                    idx_d = '0;
                    ph_d  = '0;
                    abt_d = 1'b0;
                    if (NUM_SCANS == '0) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        busy_d  = 1'b1;
                        rst_d   = 1'b1;
                        state_d = CLR;
                    end
                end
                CLR: state_d = ARM;
                ARM: begin
                    start_d = 1'b1;
                    state_d = WAIT;
                end
                // STR_DONE is only looked at here; a stale flag was cleared by the CLR pulse
                WAIT: if (STR_DONE) begin
                    start_d = 1'b0;
                    cnt_d   = tr_q;
                    state_d = (tr_q != '0) ? TR : NEXT;
                end
                TR: begin
                    if (tr_cnt == TR_WIDTH'(1)) state_d = NEXT;
                    else cnt_d = tr_cnt - TR_WIDTH'(1);
                end
                NEXT: begin
                    if (last_scan) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        idx_d   = SCAN_IDX + SCAN_WIDTH'(1);
                        ph_d    = pce_q ? SCAN_PHASE + 2'd1 : 2'd0;
                        rst_d   = 1'b1;
                        state_d = CLR;
                    end
                end
                FIN: if (!RUN) begin
                    done_d  = 1'b0;
                    abt_d   = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
